// File: rtl/regfile_write_sched_pkg.sv
// rtl/regfile_write_sched_pkg.sv - shared constants and write-request type for the register-file write scheduler
// Contents: REG_AW / REG_DW register-file geometry, ZERO_REG hard-wired register index,
//           wr_req_t queued writeback {addr, data}.
package regfile_pkg;

    localparam int REG_AW   = 3;
    localparam int REG_DW   = 16;
    localparam int ZERO_REG = 0;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [REG_DW-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/regfile_write_sched_if.sv
// rtl/regfile_write_sched_if.sv - producer, flush and register-file write bus of the write scheduler
// Signals: a_* ALU writeback handshake, b_* load writeback handshake, flush,
//          rf_we/rf_wr/rf_wd registered write port, pending per-register mask, count queue occupancy.
// Modports: master drives the producers and flush, slave is the scheduler.
interface regfile_write_sched_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 3,
    parameter int DW    = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          a_valid;
    logic          a_ready;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_data;
    logic          b_valid;
    logic          b_ready;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_data;
    logic          flush;
    logic          rf_we;
    logic [AW-1:0] rf_wr;
    logic [DW-1:0] rf_wd;
    logic [(1<<AW)-1:0] pending;
    logic [CW-1:0] count;

    modport master (
        output a_valid, a_addr, a_data,
        output b_valid, b_addr, b_data,
        output flush,
        input  a_ready, b_ready,
        input  rf_we, rf_wr, rf_wd, pending, count
    );

    modport slave (
        input  a_valid, a_addr, a_data,
        input  b_valid, b_addr, b_data,
        input  flush,
        output a_ready, b_ready,
        output rf_we, rf_wr, rf_wd, pending, count
    );

endinterface

// File: rtl/regfile_write_sched_fifo.sv
// rtl/regfile_write_sched_fifo.sv - dual-push / single-pop in-order queue of register writebacks
// Ports: clock, reset_n (async active-low), flush (sync clear),
//        push0/data0 older push, push1/data1 younger push, pop, head (entry at read pointer),
//        count occupancy, entries/valid raw storage for the pending decode.
module sched_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic                       push0,
    input  wr_req_t                    data0,
    input  logic                       push1,
    input  wr_req_t                    data1,
    input  logic                       pop,
    output wr_req_t                    head,
    output logic [$clog2(DEPTH):0]     count,
    output wr_req_t                    entries [DEPTH],
    output logic [DEPTH-1:0]           valid
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [PW-1:0]    wptr_n1;
    logic [DEPTH-1:0] valid_nxt;

    assign wptr_n1 = wptr + PW'(1);
    assign head    = entries[rptr];

    // A lone push1 takes the first free slot; with both, push0 lands first so it issues first.
    always_ff @(posedge clock) begin
        if (!flush) begin
            if (push0) begin
                entries[wptr] <= data0;
            end else if (push1) begin
                entries[wptr] <= data1;
            end
            if (push0 && push1) begin
                entries[wptr_n1] <= data1;
            end
        end
    end

    // Pop clears before pushes set: a slot being pushed is never the one being popped,
    // because a full queue accepts no pushes and an empty one does not pop.
    always_comb begin
        valid_nxt = valid;
        if (pop) begin
            valid_nxt[rptr] = 1'b0;
        end
        if (push0 || push1) begin
            valid_nxt[wptr] = 1'b1;
        end
        if (push0 && push1) begin
            valid_nxt[wptr_n1] = 1'b1;
        end
        if (flush) begin
            valid_nxt = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            valid <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            wptr  <= wptr + PW'(push0) + PW'(push1);
            rptr  <= rptr + PW'(pop);
            count <= count + CW'(push0) + CW'(push1) - CW'(pop);
            valid <= valid_nxt;
        end
    end

endmodule

// File: rtl/regfile_write_sched.sv
// rtl/regfile_write_sched.sv - two-producer write-port scheduler for the 8 x 16 register file
// Ports: clock, reset_n (async active-low), bus (slave modport): a_*/b_* writeback handshakes,
//        flush, registered rf_we/rf_wr/rf_wd write port, pending mask, count occupancy.
module regfile_write_sched
    import regfile_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = REG_AW,
    parameter int DW    = REG_DW
) (
    input  logic                  clock,
    input  logic                  reset_n,
    regfile_write_sched_if.slave  bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int NR = 1 << AW;

    logic [CW-1:0]    count;
    logic [CW-1:0]    free;
    logic             a_zero;
    logic             b_zero;
    logic             a_rdy;
    logic             b_rdy;
    logic             push_a;
    logic             push_b;
    logic             pop;
    wr_req_t          req_a;
    wr_req_t          req_b;
    wr_req_t          head;
    wr_req_t          entries [DEPTH];
    logic [DEPTH-1:0] valid;
    logic             rf_we;
    logic [AW-1:0]    rf_wr;
    logic [DW-1:0]    rf_wd;
    logic [NR-1:0]    pend;

    // Free space is taken before this cycle's pop, so a slot vacated now opens next cycle.
    assign free   = CW'(DEPTH) - count;
    assign a_zero = (bus.a_addr == AW'(ZERO_REG));
    assign b_zero = (bus.b_addr == AW'(ZERO_REG));

    // Register 0 writes are swallowed without using a slot. A claims the last slot over B.
    assign a_rdy  = !bus.flush && (a_zero || (free >= CW'(1)));
    assign b_rdy  = !bus.flush && (b_zero || (free >= CW'(2)) ||
                                   ((free == CW'(1)) && !bus.a_valid));

    assign push_a = bus.a_valid && a_rdy && !a_zero;
    assign push_b = bus.b_valid && b_rdy && !b_zero;
    assign pop    = (count != '0) && !bus.flush;

    assign req_a  = '{addr: REG_AW'(bus.a_addr), data: REG_DW'(bus.a_data)};
    assign req_b  = '{addr: REG_AW'(bus.b_addr), data: REG_DW'(bus.b_data)};

    sched_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .flush   (bus.flush),
        .push0   (push_a),
        .data0   (req_a),
        .push1   (push_b),
        .data1   (req_b),
        .pop     (pop),
        .head    (head),
        .count   (count),
        .entries (entries),
        .valid   (valid)
    );

    // Address/data hold their last value when idle; only the enable drops.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rf_we <= 1'b0;
            rf_wr <= '0;
            rf_wd <= '0;
        end else begin
            rf_we <= pop;
            if (pop) begin
                rf_wr <= AW'(head.addr);
                rf_wd <= DW'(head.data);
            end
        end
    end

    always_comb begin
        pend = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i]) begin
                pend = pend | (NR'(1) << entries[i].addr);
            end
        end
        if (rf_we) begin
            pend = pend | (NR'(1) << rf_wr);
        end
    end

    assign bus.a_ready = a_rdy;
    assign bus.b_ready = b_rdy;
    assign bus.rf_we   = rf_we;
    assign bus.rf_wr   = rf_wr;
    assign bus.rf_wd   = rf_wd;
    assign bus.pending = pend;
    assign bus.count   = count;

endmodule

// File: tb/tb_regfile_write_sched.sv
// tb/tb_regfile_write_sched.sv - scoreboard bench for regfile_write_sched
module tb_regfile_write_sched;
    import regfile_pkg::*;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;

    always #5 clock = ~clock;

    regfile_write_sched_if #(.DEPTH(4), .AW(3), .DW(16)) bus ();

    regfile_write_sched #(.DEPTH(4), .AW(3), .DW(16)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int      errors = 0;
    int      checks = 0;
    wr_req_t exp_q [$];
    wr_req_t mon_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every register-file write must match the oldest expected write.
    always @(negedge clock) begin
        if (reset_n && bus.rf_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got r%0d=0x%0h expected no write at %0t",
                         bus.rf_wr, bus.rf_wd, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("write_addr", 32'(bus.rf_wr), 32'(mon_e.addr));
                chk("write_data", 32'(bus.rf_wd), 32'(mon_e.data));
            end
        end
    end

    // One cycle of stimulus; returns at negedge+1 so callers can check state left by the previous edge.
    task automatic cyc(input logic av, input logic [2:0] aa, input logic [15:0] ad,
                       input logic bv, input logic [2:0] ba, input logic [15:0] bd,
                       input logic fl, input logic ear, input logic ebr);
        @(posedge clock);
        #1;
        bus.a_valid = av;
        bus.a_addr  = aa;
        bus.a_data  = ad;
        bus.b_valid = bv;
        bus.b_addr  = ba;
        bus.b_data  = bd;
        bus.flush   = fl;
        @(negedge clock);
        #1;
        chk("a_ready", 32'(bus.a_ready), 32'(ear));
        chk("b_ready", 32'(bus.b_ready), 32'(ebr));
        if (av && ear && aa != 3'd0) exp_q.push_back('{addr: aa, data: ad});
        if (bv && ebr && ba != 3'd0) exp_q.push_back('{addr: ba, data: bd});
        if (fl) exp_q.delete();
    endtask

    task automatic idle();
        cyc(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
        bus.b_valid = 1'b0; bus.b_addr = '0; bus.b_data = '0;
        bus.flush   = 1'b0;

        #12;
        chk("rst_rf_we",   32'(bus.rf_we),   32'd0);
        chk("rst_rf_wr",   32'(bus.rf_wr),   32'd0);
        chk("rst_rf_wd",   32'(bus.rf_wd),   32'd0);
        chk("rst_count",   32'(bus.count),   32'd0);
        chk("rst_pending", 32'(bus.pending), 32'd0);
        chk("rst_a_ready", 32'(bus.a_ready), 32'd1);
        chk("rst_b_ready", 32'(bus.b_ready), 32'd1);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // Single A write: accepted at edge 1, on the write port after edge 2.
        cyc(1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 16'h0, 1'b0, 1'b1, 1'b1);
        idle();
        chk("t1_count",   32'(bus.count),   32'd1);
        chk("t1_pending", 32'(bus.pending), 32'h08);
        chk("t1_we_lo",   32'(bus.rf_we),   32'd0);
        idle();
        chk("t1_we_hi",   32'(bus.rf_we),   32'd1);
        chk("t1_wr",      32'(bus.rf_wr),   32'd3);
        chk("t1_wd",      32'(bus.rf_wd),   32'h1234);
        chk("t1_pend_wr", 32'(bus.pending), 32'h08);
        chk("t1_count0",  32'(bus.count),   32'd0);
        idle();
        chk("t1_we_done", 32'(bus.rf_we),   32'd0);
        chk("t1_pend0",   32'(bus.pending), 32'd0);
        chk("t1_wr_hold", 32'(bus.rf_wr),   32'd3);

        // Same-cycle A and B to r5: A older, B's value is final.
        cyc(1'b1, 3'd5, 16'h0001, 1'b1, 3'd5, 16'h0002, 1'b0, 1'b1, 1'b1);
        idle();
        chk("t2_count2",  32'(bus.count),   32'd2);
        chk("t2_pending", 32'(bus.pending), 32'h20);
        idle();
        chk("t2_wd1",     32'(bus.rf_wd),   32'h0001);
        chk("t2_count1",  32'(bus.count),   32'd1);
        idle();
        chk("t2_we2",     32'(bus.rf_we),   32'd1);
        chk("t2_wd2",     32'(bus.rf_wd),   32'h0002);
        idle();
        chk("t2_pend0",   32'(bus.pending), 32'd0);

        // Back-to-back dual pushes. With one pop per cycle the queue saturates at DEPTH-1,
        // where A takes the last slot and B waits.
        cyc(1'b1, 3'd1, 16'h0011, 1'b1, 3'd2, 16'h0022, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 3'd3, 16'h0033, 1'b1, 3'd4, 16'h0044, 1'b0, 1'b1, 1'b1);
        chk("t3_count2",  32'(bus.count),   32'd2);
        cyc(1'b1, 3'd6, 16'h0066, 1'b1, 3'd7, 16'h0077, 1'b0, 1'b1, 1'b0);
        chk("t3_count3",  32'(bus.count),   32'd3);
        chk("t3_pend_a",  32'(bus.pending), 32'h1E);
        // r0 write with one slot left: accepted, consumes nothing, still blocks B.
        cyc(1'b1, 3'd0, 16'hFFFF, 1'b1, 3'd7, 16'h0077, 1'b0, 1'b1, 1'b0);
        chk("t3_count3b", 32'(bus.count),   32'd3);
        chk("t3_pend_b",  32'(bus.pending), 32'h5C);
        cyc(1'b0, 3'd0, 16'h0, 1'b1, 3'd7, 16'h0077, 1'b0, 1'b1, 1'b1);
        chk("t3_count_r0", 32'(bus.count),  32'd2);
        chk("t3_pend_c",  32'(bus.pending), 32'h58);
        for (int i = 0; i < 4; i++) idle();
        chk("t3_count0",  32'(bus.count),   32'd0);
        chk("t3_pend0",   32'(bus.pending), 32'd0);
        chk("t3_drained", 32'(exp_q.size()), 32'd0);

        // Flush with entries queued and one write in flight.
        cyc(1'b1, 3'd1, 16'h00A1, 1'b1, 3'd2, 16'h00A2, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 3'd3, 16'h00A3, 1'b0, 3'd0, 16'h0, 1'b0, 1'b1, 1'b1);
        chk("t4_count2",  32'(bus.count),   32'd2);
        cyc(1'b1, 3'd4, 16'h00A4, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 1'b0);
        chk("t4_inflight", 32'(bus.rf_we),  32'd1);
        chk("t4_pend_fl", 32'(bus.pending), 32'h0E);
        idle();
        chk("t4_count0",  32'(bus.count),   32'd0);
        chk("t4_pend0",   32'(bus.pending), 32'd0);
        chk("t4_we0",     32'(bus.rf_we),   32'd0);
        idle();
        idle();
        chk("t4_we_quiet", 32'(bus.rf_we),  32'd0);

        // Asynchronous reset mid-burst.
        cyc(1'b1, 3'd1, 16'h00B1, 1'b1, 3'd2, 16'h00B2, 1'b0, 1'b1, 1'b1);
        cyc(1'b1, 3'd3, 16'h00B3, 1'b1, 3'd4, 16'h00B4, 1'b0, 1'b1, 1'b1);
        idle();
        chk("t5_count3",  32'(bus.count),   32'd3);
        chk("t5_we1",     32'(bus.rf_we),   32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("t5_rst_we",      32'(bus.rf_we),   32'd0);
        chk("t5_rst_count",   32'(bus.count),   32'd0);
        chk("t5_rst_pending", 32'(bus.pending), 32'd0);
        exp_q.delete();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        cyc(1'b1, 3'd5, 16'h00C5, 1'b0, 3'd0, 16'h0, 1'b0, 1'b1, 1'b1);
        idle();
        chk("t5_count1",  32'(bus.count),   32'd1);
        idle();
        chk("t5_new_we",  32'(bus.rf_we),   32'd1);
        chk("t5_new_wr",  32'(bus.rf_wr),   32'd5);
        chk("t5_new_wd",  32'(bus.rf_wd),   32'h00C5);
        idle();
        chk("t5_end_pend", 32'(bus.pending), 32'd0);
        chk("final_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
